// File: rtl/nts_tx_buffer_if.sv
// nts_tx_buffer_if -- bundles the access port, transmit control and TX FIFO
// signals of nts_tx_buffer. Clock and reset stay plain ports on the module.
//
// Handshake semantics:
//   - Access port: i_access_port_wr_en is a one-cycle request. It is accepted
//     only on an edge where o_access_port_wait is low. Requests made while
//     wait is high are dropped, not queued.
//   - Transmit: i_transmit is a one-cycle pulse with the same acceptance rule
//     as a write. When a write and a transmit arrive together, the write wins.
//   - TX FIFO: o_tx_fifo_wr_en is a valid. It is never asserted while
//     i_tx_fifo_full (not-ready) is high. A word transfers on every edge where
//     wr_en is high. Data, bytes and last stay stable while full holds a word
//     back.
interface nts_tx_buffer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  i_clear;
  logic [ADDR_WIDTH+2:0] i_access_port_addr;
  logic [2:0]            i_access_port_wordsize;
  logic                  i_access_port_wr_en;
  logic [63:0]           i_access_port_wr_data;
  logic                  o_access_port_wait;
  logic                  i_transmit;
  logic                  o_tx_busy;
  logic                  i_tx_fifo_full;
  logic                  o_tx_fifo_wr_en;
  logic [63:0]           o_tx_fifo_wr_data;
  logic                  o_tx_fifo_wr_last;
  logic [3:0]            o_tx_fifo_wr_bytes;
  logic                  o_tx_done;
  logic                  o_error;

  modport slave (
    input  i_clear, i_access_port_addr, i_access_port_wordsize,
           i_access_port_wr_en, i_access_port_wr_data, i_transmit, i_tx_fifo_full,
    output o_access_port_wait, o_tx_busy, o_tx_fifo_wr_en, o_tx_fifo_wr_data,
           o_tx_fifo_wr_last, o_tx_fifo_wr_bytes, o_tx_done, o_error
  );

  modport master (
    output i_clear, i_access_port_addr, i_access_port_wordsize,
           i_access_port_wr_en, i_access_port_wr_data, i_transmit, i_tx_fifo_full,
    input  o_access_port_wait, o_tx_busy, o_tx_fifo_wr_en, o_tx_fifo_wr_data,
           o_tx_fifo_wr_last, o_tx_fifo_wr_bytes, o_tx_done, o_error
  );
endinterface

// File: rtl/nts_tx_buffer.sv
// nts_tx_buffer -- a byte-addressable, big-endian packet buffer of 64-bit
// words.
//   - Writes of 1, 2, 4 or 8 bytes are read-modify-write merges into a
//     single-port RAM. A write may span two words.
//   - A transmit pulse streams words 0..ceil(length/8)-1 to a TX FIFO. The
//     last word carries its valid byte count.
//   - Optional feature, macro NTS_TX_BUFFER_ZERO_FILL_EN: when defined, the
//     RAM is swept to zero after reset and after every clear.
module nts_tx_buffer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_areset,
  nts_tx_buffer_if.slave   bus,
  output logic [2:0]       o_dbg_state
);

  localparam int BW    = ADDR_WIDTH + 3;  // byte address width
  localparam int LW    = ADDR_WIDTH + 4;  // length width (0 .. 2^BW)
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [LW-1:0]         BUF_BYTES = LW'(DEPTH * 8);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, RD_LO, WR_LO, RD_HI, WR_HI, TX, DONE
`ifdef NTS_TX_BUFFER_ZERO_FILL_EN
    , ZERO
`endif
  } state_t;

`ifdef NTS_TX_BUFFER_ZERO_FILL_EN
  localparam state_t CLEAR_STATE = ZERO;
`else
  localparam state_t CLEAR_STATE = IDLE;
`endif

  state_t                state, next_state;
  logic                  drop_wait;     // one-cycle wait for a rejected write
  logic                  error_q;
  logic [LW-1:0]         length;
  logic [ADDR_WIDTH-1:0] lo_addr;       // first word touched by the pending write
  logic                  span_q;
  logic [127:0]          win_data_q;    // two-word window, byte 0 = MSB of lo word
  logic [15:0]           win_mask_q;
  logic [ADDR_WIDTH-1:0] word_cnt;      // TX word index / zero-fill index
  logic                  tx_valid;      // rdata holds mem[word_cnt]

  logic [63:0]           mem [DEPTH];
  logic [63:0]           rdata;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [63:0]           ram_wdata;

  // Request decode
  logic [3:0]    n_bytes;
  logic [7:0]    lane_mask;
  logic [LW-1:0] req_end;
  logic          bad_req;
  logic          span;
  logic [4:0]    win_shift;
  logic [63:0]   data_m;
  logic [127:0]  win_data;
  logic [15:0]   win_mask;
  logic          accept;
  logic          start_tx;
  logic [LW-1:0] length_m1;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [3:0]    last_bytes;
  logic          tx_show;
  logic          tx_is_last;

  function automatic logic [63:0] bytes_to_bits(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_w,
                                        input logic [63:0] new_w,
                                        input logic [7:0]  m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  // Decode the incoming write into a byte-aligned two-word window
  always_comb begin
    n_bytes   = 4'd1;
    lane_mask = 8'h01;
    case (bus.i_access_port_wordsize[1:0])
      2'd0: begin n_bytes = 4'd1; lane_mask = 8'h01; end
      2'd1: begin n_bytes = 4'd2; lane_mask = 8'h03; end
      2'd2: begin n_bytes = 4'd4; lane_mask = 8'h0f; end
      default: begin n_bytes = 4'd8; lane_mask = 8'hff; end
    endcase
    req_end   = {1'b0, bus.i_access_port_addr} + {{(LW-4){1'b0}}, n_bytes};
    bad_req   = bus.i_access_port_wordsize[2] || (req_end > BUF_BYTES);
    span      = ({1'b0, bus.i_access_port_addr[2:0]} + n_bytes) > 4'd8;
    win_shift = 5'd16 - {2'b00, bus.i_access_port_addr[2:0]} - {1'b0, n_bytes};
    data_m    = bus.i_access_port_wr_data & bytes_to_bits(lane_mask);
    win_data  = {64'd0, data_m} << {win_shift, 3'b000};
    win_mask  = {8'd0, lane_mask} << win_shift;
  end

  assign accept   = (state == IDLE) && !drop_wait && bus.i_access_port_wr_en && !bus.i_clear;
  assign start_tx = (state == IDLE) && !drop_wait && bus.i_transmit &&
                    !bus.i_access_port_wr_en && !bus.i_clear;

  assign length_m1  = length - LW'(1);
  assign last_idx   = length_m1[LW-2:3];
  assign last_bytes = {1'b0, length_m1[2:0]} + 4'd1;
  assign tx_show    = (state == TX) && tx_valid;
  assign tx_is_last = tx_show && (word_cnt == last_idx);

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept)        next_state = bad_req ? IDLE : RD_LO;
        else if (start_tx) next_state = (length == '0) ? DONE : TX;
      end
      RD_LO: next_state = WR_LO;
      WR_LO: next_state = span_q ? RD_HI : IDLE;
      RD_HI: next_state = WR_HI;
      WR_HI: next_state = IDLE;
      TX:    if (tx_is_last && !bus.i_tx_fifo_full) next_state = DONE;
      DONE:  next_state = IDLE;
`ifdef NTS_TX_BUFFER_ZERO_FILL_EN
      ZERO:  if (word_cnt == LAST_WORD) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
    if (bus.i_clear) next_state = CLEAR_STATE;
  end

  // RAM port control: merge writes, TX prefetch, zero-fill sweep
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = lo_addr;
    ram_wdata = 64'd0;
    case (state)
      RD_LO: ram_addr = lo_addr;
      WR_LO: begin
        ram_we    = 1'b1;
        ram_wdata = merge(rdata, win_data_q[127:64], win_mask_q[15:8]);
      end
      RD_HI: ram_addr = lo_addr + 1'b1;
      WR_HI: begin
        ram_we    = 1'b1;
        ram_addr  = lo_addr + 1'b1;
        ram_wdata = merge(rdata, win_data_q[63:0], win_mask_q[7:0]);
      end
      // Fetch the next word when the shown one is taken, else re-read it
      TX: ram_addr = (tx_valid && !bus.i_tx_fifo_full) ? word_cnt + 1'b1 : word_cnt;
`ifdef NTS_TX_BUFFER_ZERO_FILL_EN
      ZERO: begin
        ram_we   = 1'b1;
        ram_addr = word_cnt;
      end
`endif
      default: ram_addr = lo_addr;
    endcase
    if (bus.i_clear || i_areset) ram_we = 1'b0;
  end

  // Single-port RAM with one-cycle synchronous read
  always_ff @(posedge i_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata <= mem[ram_addr];
  end

  // State register and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state      <= CLEAR_STATE;
      drop_wait  <= 1'b0;
      error_q    <= 1'b0;
      length     <= '0;
      lo_addr    <= '0;
      span_q     <= 1'b0;
      win_data_q <= '0;
      win_mask_q <= '0;
      word_cnt   <= '0;
      tx_valid   <= 1'b0;
    end else begin
      state     <= next_state;
      drop_wait <= 1'b0;
      if (bus.i_clear) begin
        error_q  <= 1'b0;
        length   <= '0;
        word_cnt <= '0;
        tx_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (bad_req) begin
                error_q   <= 1'b1;
                drop_wait <= 1'b1;
              end else begin
                lo_addr    <= bus.i_access_port_addr[BW-1:3];
                span_q     <= span;
                win_data_q <= win_data;
                win_mask_q <= win_mask;
                if (req_end > length) length <= req_end;
              end
            end else if (start_tx) begin
              word_cnt <= '0;
              tx_valid <= 1'b0;
            end
          end
          TX: begin
            if (!tx_valid) tx_valid <= 1'b1;
            else if (!bus.i_tx_fifo_full) word_cnt <= word_cnt + 1'b1;
          end
`ifdef NTS_TX_BUFFER_ZERO_FILL_EN
          ZERO: word_cnt <= word_cnt + 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  // Outputs decoded from state; TX outputs read zero outside a shown word
  always_comb begin
    bus.o_access_port_wait = (state != IDLE) || drop_wait;
`ifdef NTS_TX_BUFFER_ZERO_FILL_EN
    bus.o_tx_busy          = (state == TX) || (state == ZERO);
`else
    bus.o_tx_busy          = (state == TX);
`endif
    bus.o_tx_fifo_wr_en    = tx_show && !bus.i_tx_fifo_full;
    bus.o_tx_fifo_wr_data  = tx_show ? rdata : 64'd0;
    bus.o_tx_fifo_wr_last  = tx_is_last;
    bus.o_tx_fifo_wr_bytes = tx_show ? (tx_is_last ? last_bytes : 4'd8) : 4'd0;
    bus.o_tx_done          = (state == DONE);
    bus.o_error            = error_q;
  end

  assign o_dbg_state = state;

endmodule
